// File: rtl/tag_matcher.sv
// Collects one trigger tag from every masked TagFIFO board and presents it with per-tag status.
// Latency: popOut one cycle after all masked boards are ready, tagValid two cycles later; held until tagAccept.
module tag_matcher #(
   parameter int NB      = 8,
   parameter int TIMEOUT = 255
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [NB-1:0]   notEmpty,
   input  logic [2*NB-1:0] tagIn,
   input  logic [NB-1:0]   overFlow,
   input  logic [NB-1:0]   boardMask,
   output logic [NB-1:0]   popOut,
   output logic            tagValid,
   output logic [1:0]      tagOut,
   input  logic            tagAccept,
   output logic            errMismatch,
   output logic            errSequence,
   output logic            errTimeout,
   output logic            errOverflow,
   output logic [NB-1:0]   missing
);

   typedef enum logic [1:0] {WAIT, POP, LATCH, PRESENT} state_t;

   localparam logic [7:0] timeoutCnt = 8'(TIMEOUT);

   state_t        state;
   logic [NB-1:0] popSet;
   logic [NB-1:0] maskReg;
   logic [NB-1:0] ready;
   logic [7:0]    counter;
   logic [1:0]    expTag;
   logic [1:0]    refTag;
   logic          timeoutFlag;
   logic          anyDiff;

   assign ready = notEmpty & boardMask;

   // Reference tag comes from the lowest-index popped board.
   always_comb begin
      refTag = 2'd0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (popSet[i]) refTag = tagIn[2*i +: 2];
      end
      anyDiff = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (popSet[i] && (tagIn[2*i +: 2] != refTag)) anyDiff = 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= WAIT;
         popOut      <= '0;
         popSet      <= '0;
         maskReg     <= '0;
         counter     <= 8'd0;
         expTag      <= 2'd0;
         timeoutFlag <= 1'b0;
         tagValid    <= 1'b0;
         tagOut      <= 2'd0;
         errMismatch <= 1'b0;
         errSequence <= 1'b0;
         errTimeout  <= 1'b0;
         errOverflow <= 1'b0;
         missing     <= '0;
      end else begin
         if ((overFlow & boardMask) != '0) errOverflow <= 1'b1;

         case (state)
            WAIT: begin
               maskReg <= boardMask;
               if (boardMask == '0 || ready == '0) begin
                  counter <= 8'd0;
               end else if (ready == boardMask) begin
                  popSet  <= boardMask;
                  popOut  <= boardMask;
                  counter <= 8'd0;
                  state   <= POP;
               end else if (counter == timeoutCnt) begin
                  // Give up on the stragglers and take what has arrived.
                  popSet      <= ready;
                  popOut      <= ready;
                  timeoutFlag <= 1'b1;
                  counter     <= 8'd0;
                  state       <= POP;
               end else begin
                  counter <= counter + 8'd1;
               end
            end
            POP: begin
               popOut <= '0;
               state  <= LATCH;
            end
            LATCH: begin
               tagOut      <= refTag;
               errMismatch <= anyDiff;
               missing     <= maskReg & ~popSet;
               errSequence <= (refTag != expTag);
               expTag      <= 2'(refTag + 2'd1);
               errTimeout  <= timeoutFlag;
               tagValid    <= 1'b1;
               state       <= PRESENT;
            end
            PRESENT: begin
               if (tagAccept) begin
                  tagValid    <= 1'b0;
                  timeoutFlag <= 1'b0;
                  state       <= WAIT;
               end
            end
            default: state <= WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_tag_matcher.sv
// Bench for tag_matcher: board FIFO model, vector table, corner sequences and randomized events.
module tb_tag_matcher;
   localparam int NB = 8;

   logic            Clock = 1'b0;
   logic            Reset;
   logic [NB-1:0]   notEmpty;
   logic [2*NB-1:0] tagIn;
   logic [NB-1:0]   overFlow;
   logic [NB-1:0]   boardMask;
   logic [NB-1:0]   popOut;
   logic            tagValid;
   logic [1:0]      tagOut;
   logic            tagAccept;
   logic            errMismatch, errSequence, errTimeout, errOverflow;
   logic [NB-1:0]   missing;

   tag_matcher #(.NB(NB), .TIMEOUT(255)) dut (
      .Clock(Clock), .Reset(Reset), .notEmpty(notEmpty), .tagIn(tagIn),
      .overFlow(overFlow), .boardMask(boardMask), .popOut(popOut),
      .tagValid(tagValid), .tagOut(tagOut), .tagAccept(tagAccept),
      .errMismatch(errMismatch), .errSequence(errSequence),
      .errTimeout(errTimeout), .errOverflow(errOverflow), .missing(missing)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [1:0] tag;
      logic       mm;
      logic       seq;
   } res_t;

   typedef struct {
      logic [NB-1:0]   mask;
      logic [2*NB-1:0] tags;
      logic [1:0]      eTag;
      logic            eMm;
      logic            eSeq;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [1:0] fq [NB][$];
   logic [1:0] dout [NB];
   bit         autoCheck = 0;
   logic [1:0] expM;
   res_t       expQ[$];
   vec_t       vt [12];
   logic [NB-1:0] seen;
   logic [1:0] t [NB];
   logic [1:0] base;
   res_t       e;
   int         lo, j, popAt, bad;
   int         hits[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NB; i++) begin
         notEmpty[i]      = (fq[i].size() != 0);
         tagIn[2*i +: 2]  = dout[i];
      end
   endtask

   task automatic consume();
      res_t x;
      chk("tag_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() == 0) return;
      x = expQ.pop_front();
      chk("rnd_tagOut", 32'(tagOut), 32'(x.tag));
      chk("rnd_mismatch", 32'(errMismatch), 32'(x.mm));
      chk("rnd_sequence", 32'(errSequence), 32'(x.seq));
      chk("rnd_timeout", 32'(errTimeout), 0);
      chk("rnd_missing", 32'(missing), 0);
   endtask

   // One clock: FIFO boards react to the popOut they saw before the edge.
   task automatic step();
      logic [NB-1:0] p;
      p = popOut;
      if (autoCheck && tagValid && tagAccept) consume();
      @(posedge Clock);
      #1;
      for (int i = 0; i < NB; i++) begin
         if (p[i]) begin
            chk("pop_nonempty", 32'(fq[i].size() != 0), 1);
            if (fq[i].size() != 0) dout[i] = fq[i].pop_front();
         end
      end
      if (autoCheck) tagAccept = ($urandom_range(0, 3) != 0);
      drive();
   endtask

   task automatic wait_valid(input int bound, output logic [NB-1:0] s);
      s = popOut;
      for (int k = 0; k < bound && !tagValid; k++) begin
         step();
         s |= popOut;
      end
      chk("valid_within_bound", 32'(tagValid), 1);
   endtask

   task automatic accept();
      tagAccept = 1'b1;
      step();
      tagAccept = 1'b0;
      chk("valid_drops", 32'(tagValid), 0);
   endtask

   task automatic push_all(input logic [NB-1:0] m, input logic [1:0] tg);
      for (int i = 0; i < NB; i++) if (m[i]) fq[i].push_back(tg);
      drive();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{8'hFF, 16'h0000, 2'd0, 1'b0, 1'b0};
      vt[1]  = '{8'hFF, 16'h5555, 2'd1, 1'b0, 1'b0};
      vt[2]  = '{8'hFF, 16'hAAAA, 2'd2, 1'b0, 1'b0};
      vt[3]  = '{8'hFF, 16'hFFFF, 2'd3, 1'b0, 1'b0};
      vt[4]  = '{8'hFF, 16'h0000, 2'd0, 1'b0, 1'b0};
      vt[5]  = '{8'hFF, 16'hAAAA, 2'd2, 1'b0, 1'b1};
      vt[6]  = '{8'hFF, 16'hFFFF, 2'd3, 1'b0, 1'b0};
      vt[7]  = '{8'hFF, 16'h0400, 2'd0, 1'b1, 1'b0};
      vt[8]  = '{8'hF0, 16'h5500, 2'd1, 1'b0, 1'b0};
      vt[9]  = '{8'h22, 16'h0C08, 2'd2, 1'b1, 1'b0};
      vt[10] = '{8'h80, 16'h0000, 2'd0, 1'b0, 1'b1};
      vt[11] = '{8'h81, 16'h4001, 2'd1, 1'b0, 1'b0};

      Reset = 1'b1; overFlow = '0; boardMask = '0; tagAccept = 1'b0;
      for (int i = 0; i < NB; i++) dout[i] = 2'd0;
      drive();
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_popOut", 32'(popOut), 0);
      chk("rst_tagValid", 32'(tagValid), 0);
      chk("rst_tagOut", 32'(tagOut), 0);
      chk("rst_errs", 32'({errMismatch, errSequence, errTimeout, errOverflow}), 0);
      chk("rst_missing", 32'(missing), 0);
      Reset = 1'b0;
      step();
      step();

      // Vector table
      for (int v = 0; v < 12; v++) begin
         boardMask = vt[v].mask;
         for (int i = 0; i < NB; i++) if (vt[v].mask[i]) fq[i].push_back(vt[v].tags[2*i +: 2]);
         drive();
         wait_valid(20, seen);
         chk("vec_popSeen", 32'(seen), 32'(vt[v].mask));
         chk("vec_tagOut", 32'(tagOut), 32'(vt[v].eTag));
         chk("vec_mismatch", 32'(errMismatch), 32'(vt[v].eMm));
         chk("vec_sequence", 32'(errSequence), 32'(vt[v].eSeq));
         chk("vec_timeout", 32'(errTimeout), 0);
         chk("vec_missing", 32'(missing), 0);
         accept();
         step();
         expM = 2'(vt[v].eTag + 2'd1);
      end

      // Latency and minimum tag period
      boardMask = 8'hFF;
      push_all(8'hFF, expM);
      step();
      chk("lat_pop", 32'(popOut), 32'hFF);
      step();
      chk("lat_pop_one_cycle", 32'(popOut), 0);
      chk("lat_valid_early", 32'(tagValid), 0);
      step();
      chk("lat_valid", 32'(tagValid), 1);
      chk("lat_tagOut", 32'(tagOut), 32'(expM));
      push_all(8'hFF, 2'(expM + 2'd1));
      push_all(8'hFF, 2'(expM + 2'd2));
      tagAccept = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (tagValid) begin
            hits.push_back(k);
            chk("period_tagOut", 32'(tagOut), 32'(2'(expM + 2'(hits.size()))));
         end
      end
      tagAccept = 1'b0;
      chk("period_hits", 32'(hits.size()), 2);
      if (hits.size() == 2) begin
         chk("period_first", 32'(hits[0]), 4);
         chk("period_gap", 32'(hits[1] - hits[0]), 4);
      end
      expM = 2'(expM + 2'd3);
      step();

      // Timeout with board 3 never arriving
      boardMask = 8'h0F;
      push_all(8'h07, expM);
      popAt = -1;
      for (int k = 1; k <= 300 && popAt < 0; k++) begin
         step();
         if (popOut != '0) popAt = k;
      end
      chk("timeout_fired", 32'(popAt != -1), 1);
      chk("timeout_window", 32'(popAt >= 250 && popAt <= 260), 1);
      chk("timeout_popOut", 32'(popOut), 32'h07);
      wait_valid(10, seen);
      chk("timeout_err", 32'(errTimeout), 1);
      chk("timeout_missing", 32'(missing), 32'h08);
      chk("timeout_tagOut", 32'(tagOut), 32'(expM));
      chk("timeout_mismatch", 32'(errMismatch), 0);
      accept();
      step();
      expM = 2'(expM + 2'd1);

      // Stall: output held while new data arrives behind it
      boardMask = 8'hFF;
      push_all(8'hFF, expM);
      wait_valid(10, seen);
      push_all(8'hFF, 2'(expM + 2'd1));
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!tagValid || tagOut != expM || popOut != '0) bad++;
      end
      chk("stall_stable", 32'(bad), 0);
      accept();
      wait_valid(10, seen);
      chk("stall_next_tag", 32'(tagOut), 32'(2'(expM + 2'd1)));
      chk("stall_next_seq", 32'(errSequence), 0);
      chk("stall_next_timeout", 32'(errTimeout), 0);
      accept();
      step();
      expM = 2'(expM + 2'd2);

      // Overflow flag
      boardMask = 8'hFB; overFlow = 8'h04;
      step();
      overFlow = '0;
      step();
      chk("ovf_masked_off", 32'(errOverflow), 0);
      boardMask = 8'h04; overFlow = 8'h04;
      step();
      overFlow = '0; boardMask = 8'hFF;
      repeat (5) step();
      chk("ovf_sticky", 32'(errOverflow), 1);

      // Reset while popOut is high
      push_all(8'hFF, expM);
      step();
      chk("rstpop_pop", 32'(popOut), 32'hFF);
      #1 Reset = 1'b1;
      #1;
      chk("rstpop_drop", 32'(popOut), 0);
      chk("rstpop_ovf_clear", 32'(errOverflow), 0);
      for (int i = 0; i < NB; i++) begin
         fq[i].delete();
         dout[i] = 2'd0;
      end
      drive();
      @(posedge Clock);
      #1 Reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (tagValid || popOut != '0) bad++;
      end
      chk("rstpop_no_tag", 32'(bad), 0);
      chk("rstpop_tagOut", 32'(tagOut), 0);
      expM = 2'd0;

      // Randomized events against the transaction model
      autoCheck = 1;
      for (int r = 0; r < 4; r++) begin
         boardMask = 8'($urandom_range(1, 255));
         lo = -1;
         for (int i = 0; i < NB; i++) if (boardMask[i] && lo < 0) lo = i;
         for (int ev = 0; ev < 20; ev++) begin
            base = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : expM;
            for (int i = 0; i < NB; i++) t[i] = base;
            if ($urandom_range(0, 4) == 0) begin
               j = $urandom_range(0, NB - 1);
               t[j] = 2'($urandom_range(0, 3));
            end
            e.tag = t[lo];
            e.mm  = 1'b0;
            for (int i = 0; i < NB; i++) if (boardMask[i] && t[i] != e.tag) e.mm = 1'b1;
            e.seq = (e.tag != expM);
            expM  = 2'(e.tag + 2'd1);
            expQ.push_back(e);
            for (int i = 0; i < NB; i++) begin
               if (boardMask[i]) begin
                  fq[i].push_back(t[i]);
                  drive();
                  if ($urandom_range(0, 2) == 0) step();
               end
            end
            step();
         end
         for (int k = 0; k < 3000 && expQ.size() != 0; k++) step();
         chk("rnd_drain", 32'(expQ.size()), 0);
         step();
      end
      autoCheck = 0;
      tagAccept = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
